// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller with HI/LO registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (md_op 6-9).
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        use_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n, op_q;
    logic [31:0] a_q, b_q, q_s, r_s, q_u, r_u;
    logic [63:0] prod_s, prod_u, res;
    logic        is_mul, is_mc, accept, done, res_we;

`ifdef MDU_MADD_EN
    assign is_mul = (md_op <= 4'd1) | ((md_op >= 4'd6) & (md_op <= 4'd9));
`else
    assign is_mul = md_op <= 4'd1;
`endif
    assign is_mc = is_mul | (md_op == 4'd2) | (md_op == 4'd3);
    assign busy  = state == RUN;
    assign stall = use_md & (busy | (start & is_mc));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        done    = 1'b0;
        if (state == IDLE) begin
            if (start && is_mc) begin
                accept  = 1'b1;
                state_n = RUN;
                cnt_n   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end
        end else if (cnt <= 4'd1) begin
            done    = 1'b1;
            state_n = IDLE;
            cnt_n   = 4'd0;
        end else begin
            cnt_n = cnt - 4'd1;
        end
    end

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign q_s    = $signed(a_q) / $signed(b_q);
    assign r_s    = $signed(a_q) % $signed(b_q);
    assign q_u    = a_q / b_q;
    assign r_u    = a_q % b_q;

    always_comb begin
        res    = {hi, lo};
        res_we = 1'b1;
        case (op_q)
            4'd0:    res = prod_s;
            4'd1:    res = prod_u;
            4'd2:    res = {r_s, q_s};
            4'd3:    res = {r_u, q_u};
`ifdef MDU_MADD_EN
            4'd6:    res = {hi, lo} + prod_s;
            4'd7:    res = {hi, lo} + prod_u;
            4'd8:    res = {hi, lo} - prod_s;
            4'd9:    res = {hi, lo} - prod_u;
`endif
            default: res_we = 1'b0;
        endcase
        // divide by zero leaves HI/LO untouched
        if (((op_q == 4'd2) || (op_q == 4'd3)) && (b_q == 32'd0)) res_we = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op_q <= md_op;
                a_q  <= a;
                b_q  <= b;
            end
            if (done && res_we) begin
                {hi, lo} <= res;
            end else if (state == IDLE && start) begin
                if (md_op == 4'd4) hi <= a;
                if (md_op == 4'd5) lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        use_md = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;
    int          vectors = 0;
    int          miscompares = 0;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .use_md(use_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        md_op = op;
        a = x;
        b = y;
        step();
        start = 1'b0;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset;
        #3;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b want 0", stall); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_mult;
        int n;
        issue(4'd0, 32'hFFFFFFFE, 32'd3);
        run_busy(n);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL mult_cycles got %0d want 5", n); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        issue(4'd1, 32'hFFFFFFFF, 32'd2);
        run_busy(n);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL multu_cycles got %0d want 5", n); end
        vectors++; if ({hi, lo} !== 64'h1_FFFFFFFE) begin miscompares++; $display("FAIL multu_hilo got %h want 1fffffffe", {hi, lo}); end
    endtask

    task automatic test_div;
        int n;
        issue(4'd3, 32'd100, 32'd7);
        run_busy(n);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL divu_cycles got %0d want 10", n); end
        vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo got %0d want 14", lo); end
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi got %0d want 2", hi); end
        issue(4'd2, 32'hFFFFFFF9, 32'd2);
        run_busy(n);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL div_cycles got %0d want 10", n); end
        vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo got %h want fffffffd", lo); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi got %h want ffffffff", hi); end
        issue(4'd2, 32'd7, 32'hFFFFFFFE);
        run_busy(n);
        vectors++; if ({hi, lo} !== {32'd1, 32'hFFFFFFFD}) begin miscompares++; $display("FAIL div_negdivisor got %h want 00000001fffffffd", {hi, lo}); end
    endtask

    task automatic test_mthi_divzero;
        int n;
        start = 1'b1;
        md_op = 4'd4;
        a = 32'h12345678;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy_start got %0b want 0", busy); end
        step();
        start = 1'b0;
        vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy got %0b want 0", busy); end
        issue(4'd5, 32'hCAFEBABE, 32'd0);
        vectors++; if (lo !== 32'hCAFEBABE || hi !== 32'h12345678 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mtlo got hi=%h lo=%h busy=%0b want 12345678 cafebabe 0", hi, lo, busy);
        end
        issue(4'd2, 32'd55, 32'd0);
        run_busy(n);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL divzero_cycles got %0d want 10", n); end
        vectors++; if ({hi, lo} !== 64'h12345678_CAFEBABE) begin miscompares++; $display("FAIL divzero_hilo got %h want 12345678cafebabe", {hi, lo}); end
    endtask

    task automatic test_stall;
        use_md = 1'b1;
        start = 1'b1;
        md_op = 4'd0;
        a = 32'd6;
        b = 32'd7;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_start got %0b want 1", stall); end
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (busy !== 1'b1 || stall !== 1'b1) begin
                miscompares++; $display("FAIL stall_busy%0d got busy=%0b stall=%0b want 1 1", i, busy, stall);
            end
            if (i == 1) begin
                start = 1'b1;
                md_op = 4'd2;
                a = 32'd100;
                b = 32'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        vectors++; if (busy !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL stall_end got busy=%0b stall=%0b want 0 0", busy, stall); end
        vectors++; if ({hi, lo} !== 64'd42) begin miscompares++; $display("FAIL stall_result got %h want 42 (2a)", {hi, lo}); end
        use_md = 1'b0;
    endtask

    task automatic test_reserved;
        issue(4'd10, 32'hDEADBEEF, 32'd1);
        vectors++; if (busy !== 1'b0 || {hi, lo} !== 64'd42) begin miscompares++; $display("FAIL reserved10 got busy=%0b hilo=%h want 0 2a", busy, {hi, lo}); end
        issue(4'd15, 32'hDEADBEEF, 32'd1);
        vectors++; if (busy !== 1'b0 || {hi, lo} !== 64'd42) begin miscompares++; $display("FAIL reserved15 got busy=%0b hilo=%h want 0 2a", busy, {hi, lo}); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(4'd1, 32'd5, 32'd5);
        run_busy(n);
        vectors++; if (lo !== 32'd25) begin miscompares++; $display("FAIL b2b_mult got %0d want 25", lo); end
        issue(4'd3, 32'd25, 32'd4);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got %0b want 1", busy); end
        run_busy(n);
        vectors++; if (n !== 10 || {hi, lo} !== {32'd1, 32'd6}) begin miscompares++; $display("FAIL b2b_div got n=%0d hilo=%h want 10 0000000100000006", n, {hi, lo}); end
    endtask

    task automatic test_abort;
        int n;
        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_prebusy got %0b want 1", busy); end
        reset = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++; $display("FAIL abort_async got busy=%0b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        vectors++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin miscompares++; $display("FAIL abort_noupdate got busy=%0b hilo=%h want 0 0", busy, {hi, lo}); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue(4'd1, 32'd3, 32'd4);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL post_reset_accept got %0b want 1", busy); end
        run_busy(n);
        vectors++; if (n !== 5 || {hi, lo} !== 64'd12) begin miscompares++; $display("FAIL post_reset_mult got n=%0d hilo=%h want 5 c", n, {hi, lo}); end
    endtask

    task automatic test_madd;
        int n;
        issue(4'd4, 32'd0, 32'd0);
        issue(4'd5, 32'hFFFFFFFF, 32'd0);
        issue(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL maddu_busy got %0b want 1", busy); end
        run_busy(n);
        vectors++; if (n !== 5 || {hi, lo} !== 64'h1_00000000) begin miscompares++; $display("FAIL maddu got n=%0d hilo=%h want 5 0000000100000000", n, {hi, lo}); end
        issue(4'd8, 32'd2, 32'hFFFFFFFF);
        run_busy(n);
        vectors++; if ({hi, lo} !== 64'h1_00000002) begin miscompares++; $display("FAIL msub got %h want 0000000100000002", {hi, lo}); end
`else
        n = 0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL maddu_off_busy got %0b want 0", busy); end
        vectors++; if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin miscompares++; $display("FAIL maddu_off_hilo got %h want 00000000ffffffff", {hi, lo}); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_divzero();
        test_stall();
        test_reserved();
        test_back_to_back();
        test_madd();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
